// File: rtl/logic_gates_cmos.sv
// rtl/logic_gates_cmos.sv - switch-level NOT/AND/OR gates with registered copies and a saturating AND-high counter
module logic_gates_cmos #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  output wire              out_NOT,
  output wire              out_AND,
  output wire              out_OR,
  output logic             reg_NOT,
  output logic             reg_AND,
  output logic             reg_OR,
  output logic [CNT_W-1:0] and_cnt
);

  supply1 vdd;
  supply0 gnd;

  wire nand_n;
  wire nand_mid;
  wire nor_n;
  wire nor_mid;

  // Inverter on A
  pmos p_not (out_NOT, vdd, A);
  nmos n_not (out_NOT, gnd, A);

  // NAND: parallel pull-up, series pull-down through nand_mid
  pmos p_nand_a (nand_n, vdd, A);
  pmos p_nand_b (nand_n, vdd, B);
  nmos n_nand_b (nand_mid, gnd, B);
  nmos n_nand_a (nand_n, nand_mid, A);

  pmos p_and (out_AND, vdd, nand_n);
  nmos n_and (out_AND, gnd, nand_n);

  // NOR: series pull-up through nor_mid, parallel pull-down
  pmos p_nor_a (nor_mid, vdd, A);
  pmos p_nor_b (nor_n, nor_mid, B);
  nmos n_nor_a (nor_n, gnd, A);
  nmos n_nor_b (nor_n, gnd, B);

  pmos p_or (out_OR, vdd, nor_n);
  nmos n_or (out_OR, gnd, nor_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_NOT <= 1'b0;
      reg_AND <= 1'b0;
      reg_OR  <= 1'b0;
      and_cnt <= '0;
    end else begin
      reg_NOT <= out_NOT;
      reg_AND <= out_AND;
      reg_OR  <= out_OR;
      // Saturate at all-ones instead of wrapping
      if (out_AND && (and_cnt != {CNT_W{1'b1}})) begin
        and_cnt <= and_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_gates_cmos.sv
// tb/tb_logic_gates_cmos.sv - self-checking bench for logic_gates_cmos
module tb_logic_gates_cmos;

  logic       clk;
  logic       rst_n;
  logic       A;
  logic       B;
  wire        out_NOT, out_AND, out_OR;
  logic       reg_NOT, reg_AND, reg_OR;
  logic [7:0] and_cnt;
  wire        s_NOT, s_AND, s_OR;
  logic       s_rNOT, s_rAND, s_rOR;
  logic [1:0] s_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit running  = 0;

  int m_reg_not, m_reg_and, m_reg_or;
  int m_cnt, m_cnt2;

  logic_gates_cmos #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B),
    .out_NOT(out_NOT), .out_AND(out_AND), .out_OR(out_OR),
    .reg_NOT(reg_NOT), .reg_AND(reg_AND), .reg_OR(reg_OR),
    .and_cnt(and_cnt)
  );

  logic_gates_cmos #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B),
    .out_NOT(s_NOT), .out_AND(s_AND), .out_OR(s_OR),
    .reg_NOT(s_rNOT), .reg_AND(s_rAND), .reg_OR(s_rOR),
    .and_cnt(s_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int f_not(int a);        return 1 - a;                 endfunction
  function automatic int f_and(int a, int b); return a * b;                 endfunction
  function automatic int f_or(int a, int b);  return (a + b > 0) ? 1 : 0;   endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: registers hold last-sampled truth-table values, counters clamp at their ceiling
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg_not = 0; m_reg_and = 0; m_reg_or = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_reg_not = f_not(int'(A));
      m_reg_and = f_and(int'(A), int'(B));
      m_reg_or  = f_or(int'(A), int'(B));
      if (m_reg_and == 1) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
    end
  end

  always @(negedge clk) begin
    if (running) begin
      check("cyc_out_NOT", int'(out_NOT), f_not(int'(A)));
      check("cyc_out_AND", int'(out_AND), f_and(int'(A), int'(B)));
      check("cyc_out_OR",  int'(out_OR),  f_or(int'(A), int'(B)));
      check("cyc_reg_NOT", int'(reg_NOT), m_reg_not);
      check("cyc_reg_AND", int'(reg_AND), m_reg_and);
      check("cyc_reg_OR",  int'(reg_OR),  m_reg_or);
      check("cyc_and_cnt", int'(and_cnt), m_cnt);
      check("cyc_small_cnt", int'(s_cnt), m_cnt2);
    end
  end

  task automatic set_ab(logic a, logic b);
    @(negedge clk);
    #2;
    A = a;
    B = b;
  endtask

  logic [3:0] tt [4];
  logic [1:0] vec [8];

  initial begin
    tt[0] = 4'b0_100; tt[1] = 4'b1_101; tt[2] = 4'b0_001; tt[3] = 4'b1_011;
    vec[0] = 2'b10; vec[1] = 2'b11; vec[2] = 2'b00; vec[3] = 2'b11;
    vec[4] = 2'b01; vec[5] = 2'b11; vec[6] = 2'b11; vec[7] = 2'b10;

    rst_n = 0;
    A = 0;
    B = 1;
    #1;
    check("lit_01_NOT", int'(out_NOT), 1);
    check("lit_01_AND", int'(out_AND), 0);
    check("lit_01_OR",  int'(out_OR),  1);

    // Truth-table sweep: index is {A,B}; entry packs {B echo, NOT, AND, OR} hand-written
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      A = ab[1];
      B = ab[0];
      #1;
      check("tt_NOT", int'(out_NOT), int'(tt[i][2]));
      check("tt_AND", int'(out_AND), int'(tt[i][1]));
      check("tt_OR",  int'(out_OR),  int'(tt[i][0]));
    end

    running = 1;
    A = 1;
    B = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg_AND", int'(reg_AND), 0);
    check("rst_and_cnt", int'(and_cnt), 0);
    check("rst_out_AND", int'(out_AND), 1);
    check("rst_out_OR",  int'(out_OR),  1);

    @(negedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    check("first_reg_NOT", int'(reg_NOT), 0);
    check("first_reg_AND", int'(reg_AND), 1);
    check("first_reg_OR",  int'(reg_OR),  1);
    repeat (4) @(posedge clk);
    #1;
    check("lit_cnt5", int'(and_cnt), 5);
    check("lit_small_sat", int'(s_cnt), 3);

    set_ab(0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("lit_hold_cnt5", int'(and_cnt), 5);
    check("lit_reg_NOT1", int'(reg_NOT), 1);
    check("lit_small_hold", int'(s_cnt), 3);

    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("async_cnt", int'(and_cnt), 0);
    check("async_reg_NOT", int'(reg_NOT), 0);
    check("async_reg_OR", int'(reg_OR), 0);
    check("async_small", int'(s_cnt), 0);
    #1;
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      set_ab(vec[i][1], vec[i][0]);
      @(posedge clk);
    end
    #1;
    check("lit_vec_cnt", int'(and_cnt), 4);
    check("lit_vec_small", int'(s_cnt), 3);
    check("lit_vec_reg_NOT", int'(reg_NOT), 0);

    @(negedge clk);
    running = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/logic_gates_cmos.md
Name: logic_gates_cmos

Overview:
- Primitive logic-gate block that computes NOT of A, AND of A and B, and OR of A and B.
- Each gate is built from CMOS switch-level transistor networks: pmos/nmos primitives tied to supply1/supply0.
- The combinational outputs are followed by a clocked sampling stage (registered copies of the gate outputs) and a saturating counter of cycles on which the AND output is high.
- Sits at the top of the transistor-gates exercise and is the unit the gate benches instantiate.

Parameters:
- CNT_W, 8, width of the AND-high cycle counter (minimum 1).

Ports:
- clk  input  1  clock; all sequential logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  1  gate input A.
- B  input  1  gate input B.
- out_NOT  output  1  combinational ~A.
- out_AND  output  1  combinational A & B.
- out_OR  output  1  combinational A | B.
- reg_NOT  output  1  out_NOT registered on clk.
- reg_AND  output  1  out_AND registered on clk.
- reg_OR  output  1  out_OR registered on clk.
- and_cnt  output  CNT_W  count of rising edges at which out_AND was 1; saturating.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. Positional port order is clk, rst_n, A, B, out_NOT, out_AND, out_OR, reg_NOT, reg_AND, reg_OR, and_cnt.
- Combinational path:
  - Purely switch-level, with no continuous-assign operators.
  - out_NOT: one pmos/nmos inverter (2 transistors).
  - out_AND: CMOS NAND (2 parallel pmos, 2 series nmos) followed by an inverter (6 transistors).
  - out_OR: CMOS NOR (2 series pmos, 2 parallel nmos) followed by an inverter (6 transistors).
  - Outputs settle within 1 time unit of any input change.
  - Outputs are independent of clk and rst_n, and are valid during reset.
- Truth table (A,B -> NOT,AND,OR): 00->1,0,0; 01->1,0,1; 10->0,0,1; 11->0,1,1.
- X or Z on A or B propagates as X (or Z) on dependent outputs. No masking is done.
- Reset: while rst_n=0, reg_NOT=0, reg_AND=0, reg_OR=0 and and_cnt=0, applied immediately without waiting for clk.
- Reset deassertion is synchronised only by usage. The first rising clk edge with rst_n=1 performs the first sample.
- Registered path, at each rising clk edge with rst_n=1:
  - reg_X takes the value out_X had just before the edge.
  - Latency is 1 cycle from a stable input to the registered output.
- Counter, at each rising clk edge with rst_n=1:
  - If out_AND=1 and and_cnt < 2^CNT_W-1, and_cnt increments by 1.
  - At 2^CNT_W-1 it holds; no wrap-around.
  - If out_AND=0 it holds.
- Reset asserted mid-operation clears the registers and counter at once. Combinational outputs keep following A/B.
- Simultaneous input change and clock edge: the register captures the pre-edge settled value. Benches shall change inputs away from clock edges.

Test Plan:
- A=0,B=1, wait 1 unit -> out_NOT=1, out_AND=0, out_OR=1.
- Sweep {A,B}=00,01,10,11 with 1-unit waits -> outputs match the truth table above, including 11 -> NOT=0, AND=1, OR=1.
- rst_n=0, A=1,B=1, toggle clk -> reg_*=0 and and_cnt=0 throughout; out_AND=1 and out_OR=1 still valid.
- Release reset, hold A=1,B=1 for 5 rising edges -> reg_NOT=0, reg_AND=1, reg_OR=1 after first edge; and_cnt=5. Then A=0 for 3 edges -> and_cnt stays 5, reg_NOT=1.
- CNT_W=2, A=B=1 for 6 edges -> and_cnt reaches 3 and holds at 3.
- With and_cnt=5, pulse rst_n low between clock edges -> and_cnt and reg_* go to 0 immediately, before the next edge.
